// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built from a single full-adder stage (two half adders) and
// a carry flop. Operands are shifted through LSB first, one bit per clock.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   rst    - synchronous active-high reset
//   start  - begin an addition; sampled only while idle
//   a, b   - operands, captured on the accepting edge
//   c_in   - carry-in, captured on the accepting edge
//   busy   - high while bits are being added
//   done   - one-cycle pulse when sum/carry hold a new result
//   sum    - registered result, low WIDTH bits of a+b+c_in
//   carry  - registered carry-out (bit WIDTH of a+b+c_in)
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Counter must hold 0..WIDTH; never narrower than one bit.
  localparam int unsigned CntW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_sh_q;
  logic [WIDTH-1:0]  b_sh_q;
  logic [WIDTH-1:0]  res_q;
  logic              cy_q;
  logic [CntW-1:0]   cnt_q;

  logic              ha1_s;
  logic              ha1_c;
  logic              fa_s;
  logic              fa_c;
  logic [WIDTH-1:0]  res_d;
  logic              last_bit;

  // Full adder as two cascaded half adders.
  always_comb begin
    ha1_s = a_sh_q[0] ^ b_sh_q[0];
    ha1_c = a_sh_q[0] & b_sh_q[0];
    fa_s  = ha1_s ^ cy_q;
    fa_c  = ha1_c | (ha1_s & cy_q);
  end

  // New result bit enters at the MSB end; after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    res_d            = res_q >> 1;
    res_d[WIDTH-1]   = fa_s;
    last_bit         = (cnt_q == CntW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      carry   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            cy_q    <= c_in;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          res_q  <= res_d;
          cy_q   <= fa_c;
          cnt_q  <= cnt_q + CntW'(1);
          if (last_bit) begin
            sum     <= res_d;
            carry   <= fa_c;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (WIDTH 8, 1, 16) share one clock. A transaction-level
// model predicts busy/done/sum/carry each cycle from plain arithmetic on the accepted operands;
// directed cases also pin literal results and latency.
module tb_serial_adder;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [NI];
  logic        start_v [NI];
  logic [63:0] a_v     [NI];
  logic [63:0] b_v     [NI];
  logic        c_v     [NI];
  logic        busy_v  [NI];
  logic        done_v  [NI];
  logic        carry_v [NI];
  logic [63:0] sum_v   [NI];

  logic [7:0]  sum8;
  logic [0:0]  sum1;
  logic [15:0] sum16;

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
    .c_in(c_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum8), .carry(carry_v[0])
  );
  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .a(a_v[1][0:0]), .b(b_v[1][0:0]),
    .c_in(c_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .carry(carry_v[1])
  );
  serial_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .a(a_v[2][15:0]), .b(b_v[2][15:0]),
    .c_in(c_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum16), .carry(carry_v[2])
  );

  always_comb begin
    sum_v[0] = 64'(sum8);
    sum_v[1] = 64'(sum1);
    sum_v[2] = 64'(sum16);
  end

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  function automatic int width_of(int g);
    return (g == 0) ? 8 : (g == 1) ? 1 : 16;
  endfunction

  function automatic void check(string nm, int g, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[w%0d] at %0t: got %0h expected %0h", nm, width_of(g), $time, act, exp);
    end
  endfunction

  // Transaction model: 0 = idle, 1 = adding (rem cycles left), 2 = result pulse.
  int          m_mode  [NI];
  int          m_rem   [NI];
  logic        m_busy  [NI];
  logic        m_done  [NI];
  logic [63:0] m_sum   [NI];
  logic        m_carry [NI];
  logic [63:0] m_psum  [NI];
  logic        m_pcar  [NI];

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      int          w;
      logic [63:0] mask;
      logic [64:0] full;
      w    = width_of(g);
      mask = (64'd1 << w) - 64'd1;
      if (rst_v[g]) begin
        m_mode[g] = 0; m_rem[g] = 0; m_busy[g] = 1'b0; m_done[g] = 1'b0;
        m_sum[g] = '0; m_carry[g] = 1'b0;
      end else if (m_mode[g] == 2) begin
        m_mode[g] = 0;
        m_done[g] = 1'b0;
      end else if (m_mode[g] == 1) begin
        m_rem[g]--;
        if (m_rem[g] == 0) begin
          m_mode[g]  = 2;
          m_busy[g]  = 1'b0;
          m_done[g]  = 1'b1;
          m_sum[g]   = m_psum[g];
          m_carry[g] = m_pcar[g];
        end
      end else if (start_v[g]) begin
        full      = {1'b0, a_v[g] & mask} + {1'b0, b_v[g] & mask} + 65'(c_v[g]);
        m_psum[g] = full[63:0] & mask;
        m_pcar[g] = full[w];
        m_rem[g]  = w;
        m_mode[g] = 1;
        m_busy[g] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < NI; g++) begin
        check("busy", g, 64'(busy_v[g]), 64'(m_busy[g]));
        check("done", g, 64'(done_v[g]), 64'(m_done[g]));
        check("sum", g, sum_v[g], m_sum[g]);
        check("carry", g, 64'(carry_v[g]), 64'(m_carry[g]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One addition on instance g; checks literal result and E0-to-done latency.
  task automatic run_add(int g, logic [63:0] av, logic [63:0] bv, logic ci, bit hold,
                         logic [63:0] es, logic ec);
    int lat;
    bit got;
    a_v[g] = av; b_v[g] = bv; c_v[g] = ci; start_v[g] = 1'b1;
    step();
    if (!hold) start_v[g] = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (hold) begin
        a_v[g] = {$urandom, $urandom};
        b_v[g] = {$urandom, $urandom};
      end
      step();
      lat++;
      if (done_v[g]) got = 1'b1;
    end
    start_v[g] = 1'b0;
    check("done_seen", g, 64'(got), 64'd1);
    check("latency", g, 64'(lat), 64'(width_of(g)));
    check("sum_lit", g, sum_v[g], es);
    check("carry_lit", g, 64'(carry_v[g]), 64'(ec));
    step();
    step();
  endtask

  initial begin
    int          n_done;
    logic [63:0] av, bv;
    for (int g = 0; g < NI; g++) begin
      rst_v[g] = 1'b1; start_v[g] = 1'b0; a_v[g] = '0; b_v[g] = '0; c_v[g] = 1'b0;
    end
    // start together with reset must be ignored
    start_v[0] = 1'b1;
    a_v[0] = 64'h0F; b_v[0] = 64'h01;
    step();
    chk_en = 1'b1;
    step();
    check("busy_after_rst_start", 0, 64'(busy_v[0]), 64'd0);
    check("sum_reset", 0, sum_v[0], 64'd0);
    for (int g = 0; g < NI; g++) rst_v[g] = 1'b0;
    start_v[0] = 1'b0;
    step();

    // WIDTH = 8 directed
    run_add(0, 64'h0F, 64'h01, 1'b0, 1'b0, 64'h10, 1'b0);
    run_add(0, 64'hFF, 64'h01, 1'b0, 1'b0, 64'h00, 1'b1);
    run_add(0, 64'hFF, 64'hFF, 1'b1, 1'b0, 64'hFF, 1'b1);
    // start held and operands scrambled during the addition
    run_add(0, 64'h3C, 64'h0A, 1'b1, 1'b1, 64'h47, 1'b0);

    // reset in the middle of an addition
    a_v[0] = 64'h55; b_v[0] = 64'h22; c_v[0] = 1'b0; start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    step(); step(); step();
    rst_v[0] = 1'b1;
    step();
    rst_v[0] = 1'b0;
    check("busy_abort", 0, 64'(busy_v[0]), 64'd0);
    check("sum_abort", 0, sum_v[0], 64'd0);
    check("carry_abort", 0, 64'(carry_v[0]), 64'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("no_done_abort", 0, 64'(done_v[0]), 64'd0);
    end
    run_add(0, 64'h12, 64'h34, 1'b0, 1'b0, 64'h46, 1'b0);

    // WIDTH = 1 exhaustive
    for (int i = 0; i < 8; i++) begin
      int t;
      t = i[2] + i[1] + i[0];
      run_add(1, 64'(i[2]), 64'(i[1]), i[0], 1'b0, 64'(t & 1), t[1]);
    end

    // WIDTH = 16 random: start and operands toggle freely, model tracks acceptance
    n_done = 0;
    for (int cyc = 0; cyc < 40000 && n_done < 500; cyc++) begin
      av = 64'($urandom);
      bv = 64'($urandom);
      start_v[2] = ($urandom_range(0, 3) != 0);
      a_v[2] = av; b_v[2] = bv; c_v[2] = $urandom_range(0, 1) == 1;
      step();
      if (done_v[2]) n_done++;
    end
    start_v[2] = 1'b0;
    check("w16_done_count", 2, 64'(n_done), 64'd500);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  first operand; captured on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  second operand; captured on the accepting edge.
REQ-007 SHALL have port c_in  input  1  carry-in; captured on the accepting edge.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress (RUN state).
REQ-009 SHALL have port done  output  1  one-cycle pulse; sum and carry are newly valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result, a+b+c_in modulo 2^WIDTH.
REQ-011 SHALL have port carry  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-012 SHALL add bit-serially, LSB first, through exactly one full-adder stage, which is two half-adder stages (sum = x^y^cy, carry = x&y | cy&(x^y)), plus a carry flip-flop.
REQ-013 SHALL use a three-state FSM with states IDLE, RUN and DONE.
REQ-014 IDLE: when start=1 at an edge (the accepting edge E0), a, b and c_in SHALL be loaded into internal shift registers and the carry flop, bit counter = 0, next state RUN.
REQ-015 RUN: on each edge, the adder stage SHALL consume LSB(a_sh), LSB(b_sh) and the carry flop, shift the result bit into the internal result register from the MSB end, update the carry flop, and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH edges (E1..E_WIDTH); on E_WIDTH, sum and carry SHALL load the final result and the next state SHALL be DONE.
REQ-017 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-018 Latency: done SHALL be high exactly in the cycle following E_WIDTH, i.e. WIDTH cycles after the accepting edge; one result every WIDTH+2 cycles maximum throughput.
REQ-019 busy SHALL be 1 exactly while the state is RUN; done SHALL be 1 exactly while the state is DONE; the two SHALL never both be 1.
REQ-020 start SHALL be ignored in RUN and DONE; a and b changing after E0 SHALL NOT affect the result.
REQ-021 sum and carry SHALL hold their last result until the next completion; they SHALL NOT change during RUN.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits, minimum 1; WIDTH=1 SHALL complete in one RUN edge.
REQ-023 Overflow SHALL wrap: the result SHALL be the low WIDTH bits of a+b+c_in, with bit WIDTH on carry.

Reset
REQ-024 With rst=1 at an edge, the state SHALL become IDLE, and busy, done, sum, carry, the counter and the carry flop SHALL all become 0.
REQ-025 rst SHALL take priority over start and over any in-progress addition; an aborted addition SHALL produce no done pulse and SHALL leave sum=0 and carry=0.
REQ-026 start asserted in the same cycle as rst SHALL be ignored; the first start accepted SHALL be one sampled with rst=0.

Verification
REQ-027 WIDTH=8, a=0x0F, b=0x01, c_in=0, start at E0 -> busy high for 8 cycles, done in the cycle after E8, sum=0x10, carry=0.
REQ-028 WIDTH=8, a=0xFF, b=0x01, c_in=0 -> sum=0x00, carry=1; a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, carry=1.
REQ-029 WIDTH=8: start held high and a/b changed during RUN -> single done, result from the E0 operands, no second start until IDLE.
REQ-030 WIDTH=8, rst pulsed at E4 of an addition -> no done, busy=0, sum=0x00, carry=0; next addition 0x12+0x34 -> 0x46, carry=0.
REQ-031 WIDTH=1: all 8 (a,b,c_in) combinations -> done one cycle after E1 and {carry,sum} equal to a+b+c_in.
REQ-032 WIDTH=16: 500 random operand sets, checked against a+b+c_in -> all match, and done/busy timing as in REQ-018 and REQ-019.
